// File: rtl/seq_divider.sv
// seq_divider: 16-bit signed sequential divider (restoring algorithm).
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   dividend, divisor     signed operands, captured when src_valid && src_ready
//   src_valid / src_ready operand handshake (src_ready high only in IDLE)
//   quotient, remainder   signed result, held stable while dest_valid is high
//   dest_valid/dest_ready result handshake (dest_valid high only in DONE)
//   div_by_zero           present only when SEQ_DIVIDER_DBZ_FLAG_EN is defined
//   dbg_state             current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits on ready, and the producer holds data stable until the
// transfer completes.
//
// Timing: accept on edge k, 16 iterations on edges k+1..k+16, dest_valid high
// after edge k+16 regardless of operand values.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        dest_valid,
  input  logic        dest_ready,
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  output logic        div_by_zero,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dvd_q, dvd_d;          // raw dividend: sign source and div-by-zero remainder
  logic        dvs_neg_q, dvs_neg_d;
  logic [16:0] dvs_mag_q, dvs_mag_d;
  logic [15:0] quo_q, quo_d;          // dividend magnitude shifts out, quotient bits shift in
  logic [16:0] acc_q, acc_d;          // partial remainder
  logic [15:0] quotient_q, quotient_d;
  logic [15:0] remainder_q, remainder_d;
  logic        dest_valid_q, dest_valid_d;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  logic        dbz_q, dbz_d;
`endif

  // 17-bit magnitudes so that |-32768| = 0x8000 is representable.
  logic [16:0] in_dvd_mag, in_dvs_mag;
  assign in_dvd_mag = dividend[15] ? (17'd0 - {dividend[15], dividend}) : {1'b0, dividend};
  assign in_dvs_mag = divisor[15]  ? (17'd0 - {divisor[15],  divisor})  : {1'b0, divisor};

  // One restoring step: shift in next dividend bit, subtract if it fits.
  logic [16:0] shifted;
  logic [17:0] diff;
  logic        fits;
  logic [16:0] acc_next;
  logic [15:0] quo_next;
  logic [15:0] q_signed, r_signed;

  always_comb begin
    shifted  = {acc_q[15:0], quo_q[15]};
    diff     = {1'b0, shifted} - {1'b0, dvs_mag_q};
    fits     = ~diff[17];
    acc_next = fits ? diff[16:0] : shifted;
    quo_next = {quo_q[14:0], fits};
    // Quotient magnitude 0x8000 negates to itself, which covers -32768/-1 and -32768/1.
    q_signed = (dvd_q[15] ^ dvs_neg_q) ? (16'd0 - quo_next) : quo_next;
    r_signed = dvd_q[15] ? (16'd0 - acc_next[15:0]) : acc_next[15:0];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dvd_d        = dvd_q;
    dvs_neg_d    = dvs_neg_q;
    dvs_mag_d    = dvs_mag_q;
    quo_d        = quo_q;
    acc_d        = acc_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    dest_valid_d = dest_valid_q;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
    dbz_d        = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (src_valid) begin
          state_d   = CALC;
          cnt_d     = 4'd0;
          dvd_d     = dividend;
          dvs_neg_d = divisor[15];
          dvs_mag_d = in_dvs_mag;
          quo_d     = in_dvd_mag[15:0];
          acc_d     = 17'd0;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
          dbz_d     = (divisor == 16'd0);
`endif
        end
      end
      CALC: begin
        acc_d = acc_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d      = DONE;
          dest_valid_d = 1'b1;
          if (dvs_mag_q == 17'd0) begin
            quotient_d  = 16'hFFFF;
            remainder_d = dvd_q;
          end else begin
            quotient_d  = q_signed;
            remainder_d = r_signed;
          end
        end
      end
      DONE: begin
        if (dest_ready) begin
          state_d      = IDLE;
          dest_valid_d = 1'b0;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
          dbz_d        = 1'b0;
`endif
        end
      end
      default: begin
        state_d      = IDLE;
        dest_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      dvd_q        <= 16'd0;
      dvs_neg_q    <= 1'b0;
      dvs_mag_q    <= 17'd0;
      quo_q        <= 16'd0;
      acc_q        <= 17'd0;
      quotient_q   <= 16'd0;
      remainder_q  <= 16'd0;
      dest_valid_q <= 1'b0;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      dbz_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dvd_q        <= dvd_d;
      dvs_neg_q    <= dvs_neg_d;
      dvs_mag_q    <= dvs_mag_d;
      quo_q        <= quo_d;
      acc_q        <= acc_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
      dest_valid_q <= dest_valid_d;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
      dbz_q        <= dbz_d;
`endif
    end
  end

  assign src_ready  = (state_q == IDLE);
  assign quotient   = quotient_q;
  assign remainder  = remainder_q;
  assign dest_valid = dest_valid_q;
  assign dbg_state  = state_q;
`ifdef SEQ_DIVIDER_DBZ_FLAG_EN
  assign div_by_zero = dbz_q;
`endif

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 dividend  input  16  signed two's-complement dividend, sampled on accept.
REQ-004 divisor  input  16  signed two's-complement divisor, sampled on accept.
REQ-005 src_valid  input  1  operands valid.
REQ-006 src_ready  output  1  block can accept operands; high only in IDLE.
REQ-007 quotient  output  16  signed quotient, stable while dest_valid is high.
REQ-008 remainder  output  16  signed remainder, stable while dest_valid is high.
REQ-009 dest_valid  output  1  result valid; high only in DONE.
REQ-010 dest_ready  input  1  consumer accepts the result.

Function
REQ-011 Accept SHALL occur on a rising edge with src_valid and src_ready both high; the operands are registered, and the FSM moves IDLE->CALC.
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE. CALC->DONE occurs after iteration 15. DONE->IDLE occurs on the edge where dest_valid and dest_ready are both high.
REQ-013 CALC SHALL perform one restoring shift/subtract iteration per clock on operand magnitudes, using a 4-bit counter that runs 0..15.
REQ-014 Latency SHALL be fixed: after an accept on edge k, dest_valid is high after edge k+16, independent of operand values, including the special cases below.
REQ-015 The quotient SHALL truncate toward zero; it is negated when the operand signs differ.
REQ-016 The remainder sign SHALL follow the dividend, with |remainder| < |divisor| and dividend = quotient*divisor + remainder.
REQ-017 Divide by zero SHALL produce quotient = 16'hFFFF and remainder = dividend.
REQ-018 Overflow (-32768 / -1) SHALL produce quotient = -32768 and remainder = 0.
REQ-019 Magnitudes SHALL be held in 17-bit intermediates so that |-32768| does not overflow.
REQ-020 In DONE with dest_ready low, the block SHALL hold quotient, remainder and dest_valid indefinitely.
REQ-021 src_ready SHALL be low in CALC and DONE; operand changes there SHALL be ignored.
REQ-022 There SHALL be no back-to-back bypass: the next accept occurs no earlier than the cycle after DONE->IDLE.

Reset
REQ-023 Asserting rst_n low SHALL immediately force IDLE, counter = 0, quotient = 0, remainder = 0, dest_valid = 0 and src_ready = 1 (src_ready reflects IDLE), with div_by_zero = 0 when present.
REQ-024 Reset in CALC or DONE SHALL abort the operation; no stale result SHALL appear after reset is released.
REQ-025 The first accept after reset SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-026 With macro SEQ_DIVIDER_DBZ_FLAG_EN defined, the block SHALL add output div_by_zero (1 bit). It is registered on accept, high with dest_valid when divisor = 0, and cleared on DONE->IDLE.
REQ-027 Without SEQ_DIVIDER_DBZ_FLAG_EN, the div_by_zero port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Accept 100 / 7 with dest_ready = 1 -> dest_valid is high exactly 16 cycles after accept, quotient = 14, remainder = 2; src_ready returns high on the next cycle.
REQ-029 Accept -100 / 7, then 100 / -7, then -100 / -7 -> results (-14, -2), (-14, 2) and (14, -2).
REQ-030 Accept 1234 / 0 -> quotient = 16'hFFFF, remainder = 1234 after 16 cycles; div_by_zero = 1 when SEQ_DIVIDER_DBZ_FLAG_EN is defined.
REQ-031 Accept -32768 / -1, then -32768 / 1 -> results (-32768, 0) and (-32768, 0).
REQ-032 Hold dest_ready = 0 for 10 cycles in DONE while toggling src_valid and the operands -> outputs are unchanged and src_ready = 0; raising dest_ready gives IDLE on the next edge.
REQ-033 Pull rst_n low at CALC iteration 8 -> outputs are at reset values immediately; a new 15 / 4 accept after release returns (3, 3).
